cache_arbiter: RTL
==================

Name: cache_arbiter

Overview:
- Shares the single downstream memory port (L2 / physical memory) between the instruction cache and the data cache.
- Each cache issues whole-line transactions: 256-bit lines, 32-bit line-aligned address, with its usual downstream read/write/resp handshake.
- The arbiter grants one requester at a time, registers the granted command, drives it downstream until mem_resp, then returns read data and a one-cycle resp to the winner.
- Ties use round-robin so neither cache starves.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  I-cache line read request.
- i_address  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line data to I-cache.
- i_resp  out  1  I-cache transaction complete.
- d_read  in  1  D-cache line read request.
- d_write  in  1  D-cache line writeback request.
- d_address  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache writeback data.
- d_rdata  out  LINE_W  line data to D-cache.
- d_resp  out  1  D-cache transaction complete.
- mem_read  out  1  downstream read command.
- mem_write  out  1  downstream write command.
- mem_address  out  ADDR_W  downstream address.
- mem_wdata  out  LINE_W  downstream write data.
- mem_rdata  in  LINE_W  downstream read data.
- mem_resp  in  1  downstream transaction complete.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Flop last_served ∈ {I, D}.
- Reset: state=IDLE, last_served=I.
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, i_resp=0, d_resp=0.
- rdata outputs reset to 0 and may be don't-care whenever resp is low.
- IDLE, no request (i_read=0, d_read=0, d_write=0): stay in IDLE, drive nothing.
- IDLE, only I requests: go to SERVE_I.
- IDLE, only D requests: go to SERVE_D.
- IDLE, both request: grant the one that is not last_served. After reset D wins the first tie.
- Grant edge: register mem_address, mem_wdata and op from the winner.
  - I grant → op=read.
  - D grant → op=write if d_write, else read.
  - d_read and d_write both high is illegal; write wins.
- mem_read/mem_write are registered. They assert in the first SERVE cycle and stay high, address and data stable, through the cycle in which mem_resp=1.
- SERVE_x when mem_resp=1 (same cycle, combinational):
  - x_resp=1 and x_rdata=mem_rdata.
  - Next state IDLE; last_served←x.
  - mem_read/mem_write clear on that edge.
- SERVE_x when mem_resp=0: hold state, command, address and data unchanged.
- Requester inputs are ignored during SERVE; the latched command is authoritative. A requester that drops its request mid-transaction does not abort it.
- The non-granted requester keeps its request high and is served on the next IDLE. It receives no resp until then.
- Minimum one IDLE cycle between transactions. Requesters deassert in the cycle after resp, so a request is never re-granted twice.
- Latency: request seen in IDLE at cycle t → mem command at t+1 → resp in the same cycle as mem_resp. Minimum total is 2 cycles when mem_resp arrives at t+1.
- mem_resp while IDLE: ignored, no resp generated.
- At most one of i_resp/d_resp is high in any cycle, and never while IDLE.
- rst asserted mid-SERVE: on that edge return to IDLE, deassert mem commands and suppress resp. A late mem_resp arriving afterwards is ignored.

Test Plan:
- Reset then idle: rst 1 cycle, no requests for 5 cycles → mem_read=mem_write=0, i_resp=d_resp=0 throughout.
- Solo I read: i_read=1, i_address=0x0000_1040; mem_resp after 3 cycles with mem_rdata=0xA5…A5 →
  - mem_read=1 with mem_address=0x0000_1040 held;
  - i_resp pulses 1 cycle with i_rdata=0xA5…A5;
  - state returns to IDLE; d_resp stays 0.
- D writeback: d_write=1, d_address=0x8000_0020, d_wdata=0x1234…; hold d_wdata through the transaction →
  - mem_write=1, mem_wdata equals the latched value;
  - d_resp pulses on mem_resp.
- Tie round-robin: i_read and d_read both high after reset → D served first (mem_address=d_address). The next IDLE grants I. A third simultaneous tie grants D again.
- Requester holding: I requests while D is being served (mem_resp delayed 6 cycles) → mem_address unchanged during the D transaction; I granted the cycle after returning to IDLE.
- Reset mid-transaction: assert rst in the 2nd SERVE_D cycle, then pulse mem_resp → no d_resp, mem_write=0 after the reset edge, state IDLE, next tie goes to D.

Source files
------------

// File: rtl/cache_arbiter.sv
// Shares one downstream line-wide memory port between the I-cache and D-cache.
// Round-robin on ties; the granted command is latched and held until mem_resp.
module cache_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_d, w_last_d_nxt;
  logic              r_mem_read, w_mem_read_nxt;
  logic              r_mem_write, w_mem_write_nxt;
  logic [ADDR_W-1:0] r_mem_address, w_mem_address_nxt;
  logic [LINE_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              w_d_req;
  logic              w_grant_i;
  logic              w_grant_d;

  // Tie goes to whichever requester was not served last.
  assign w_d_req   = d_read | d_write;
  assign w_grant_i = i_read & (~w_d_req | r_last_d);
  assign w_grant_d = w_d_req & (~i_read | ~r_last_d);

  always_comb begin
    w_state_nxt       = r_state;
    w_last_d_nxt      = r_last_d;
    w_mem_read_nxt    = r_mem_read;
    w_mem_write_nxt   = r_mem_write;
    w_mem_address_nxt = r_mem_address;
    w_mem_wdata_nxt   = r_mem_wdata;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt       = SERVE_D;
          w_mem_write_nxt   = d_write;
          w_mem_read_nxt    = ~d_write;
          w_mem_address_nxt = d_address;
          w_mem_wdata_nxt   = d_wdata;
        end else if (w_grant_i) begin
          w_state_nxt       = SERVE_I;
          w_mem_read_nxt    = 1'b1;
          w_mem_write_nxt   = 1'b0;
          w_mem_address_nxt = i_address;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          w_state_nxt     = IDLE;
          w_last_d_nxt    = (r_state == SERVE_D);
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_last_d      <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_d      <= w_last_d_nxt;
      r_mem_read    <= w_mem_read_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
    end
  end

  // Completion is reported in the same cycle as mem_resp; suppressed under reset.
  assign i_resp = ~rst & mem_resp & (r_state == SERVE_I);
  assign d_resp = ~rst & mem_resp & (r_state == SERVE_D);

  assign i_rdata     = i_resp ? mem_rdata : '0;
  assign d_rdata     = d_resp ? mem_rdata : '0;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;

endmodule
